// File: rtl/ahb_sram_sub_if.sv
// AHB-Lite bus bundle between a manager and the SRAM subordinate.
interface ahb_sram_sub_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   haddr;
   logic [1:0]              htrans;
   logic                    hwrite;
   logic [2:0]              hsize;
   logic [2:0]              hburst;
   logic [3:0]              hprot;
   logic                    hmastlock;
   logic [DATA_WIDTH-1:0]   hwdata;
   logic [DATA_WIDTH/8-1:0] hwstrb;
   logic                    hready;
   logic                    hresp;
   logic [DATA_WIDTH-1:0]   hrdata;

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hwstrb,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hwstrb,
      output hready, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_sub.sv
// AHB-Lite SRAM subordinate with configurable wait states and two-cycle ERROR.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_READY | HREADY=1, HRESP=0; completes a data phase, accepts addresses
// ST_WAIT  | HREADY=0, HRESP=0; wait counter runs down to zero
// ST_ERR1  | HREADY=0, HRESP=1; first cycle of the ERROR response
// ST_ERR2  | HREADY=1, HRESP=1; second cycle, bus may advance
module ahb_sram_sub #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic           i_hclk,
   input  logic           i_hresetn,
   ahb_sram_sub_if.slave  bus
);
   localparam int LP_IDX_W = $clog2(DEPTH);
   localparam int LP_LANES = DATA_WIDTH / 8;
   localparam logic [2:0] LP_WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [2:0]            r_cnt;
   logic                  r_valid;
   logic                  r_write;
   logic [LP_IDX_W-1:0]   r_idx;
   logic [LP_LANES-1:0]   r_mask;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_hready;
   logic                  w_hresp;
   logic [DATA_WIDTH-1:0] w_hrdata;
   logic                  w_sample;
   logic                  w_illegal;
   logic                  w_start;
   logic [LP_LANES-1:0]   w_mask;
   logic                  w_unused;

   assign w_unused = ^{bus.hburst, bus.hprot, bus.hmastlock};

   // An address phase is only taken on a HREADY=1 edge with NONSEQ or SEQ.
   assign w_sample = w_hready & bus.htrans[1];
   assign w_start  = w_sample & ~w_illegal;

   // Legality: in-range word index, supported size, natural alignment.
   always_comb begin
      w_illegal = 1'b0;
      if (|bus.haddr[ADDR_WIDTH-1:LP_IDX_W+2]) w_illegal = 1'b1;
      if (bus.hsize > 3'd2)                    w_illegal = 1'b1;
      if (bus.hsize == 3'd1 && bus.haddr[0])   w_illegal = 1'b1;
      if (bus.hsize == 3'd2 && |bus.haddr[1:0]) w_illegal = 1'b1;
   end

   // Byte lanes covered by the transfer footprint.
   always_comb begin
      w_mask = '0;
      case (bus.hsize)
         3'd0:    w_mask = LP_LANES'(1) << bus.haddr[1:0];
         3'd1:    w_mask = bus.haddr[1] ? LP_LANES'(4'b1100) : LP_LANES'(4'b0011);
         default: w_mask = '1;
      endcase
   end

   // State register.
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) r_state <= ST_READY;
      else            r_state <= w_next_state;
   end

   // Next-state logic; ERR2 drives HREADY=1 so it accepts addresses like READY.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_READY, ST_ERR2: begin
            w_next_state = ST_READY;
            if (w_sample) begin
               if (w_illegal)            w_next_state = ST_ERR1;
               else if (WAIT_STATES > 0) w_next_state = ST_WAIT;
            end
         end
         ST_WAIT:  w_next_state = (r_cnt == 3'd0) ? ST_READY : ST_WAIT;
         ST_ERR1:  w_next_state = ST_ERR2;
         default:  w_next_state = ST_READY;
      endcase
   end

   // Outputs decoded from state; read data comes straight from the array so a
   // write committed on the previous edge is already visible to the next read.
   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      case (r_state)
         ST_WAIT: w_hready = 1'b0;
         ST_ERR1: begin
            w_hready = 1'b0;
            w_hresp  = 1'b1;
         end
         ST_ERR2: w_hresp = 1'b1;
         default: ;
      endcase
      w_hrdata = (r_valid && !r_write) ? r_mem[r_idx] : '0;
   end

   assign bus.hready = w_hready;
   assign bus.hresp  = w_hresp;
   assign bus.hrdata = w_hrdata;

   // Wait-state down-counter.
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn)                 r_cnt <= 3'd0;
      else if (r_state == ST_WAIT)    r_cnt <= (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
      else if (w_start)               r_cnt <= LP_WS_LOAD;
   end

   // Pending transfer captured in the address phase, retired when HREADY=1.
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) begin
         r_valid <= 1'b0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_mask  <= '0;
      end else if (w_hready) begin
         r_valid <= w_start;
         if (w_start) begin
            r_write <= bus.hwrite;
            r_idx   <= bus.haddr[LP_IDX_W+1:2];
            r_mask  <= w_mask;
         end
      end
   end

   // Storage write on the final data-phase edge; contents survive reset.
   always_ff @(posedge i_hclk) begin
      if (i_hresetn && r_valid && r_write && w_hready) begin
         for (int n = 0; n < LP_LANES; n++) begin
            if (bus.hwstrb[n] && r_mask[n]) r_mem[r_idx][8*n +: 8] <= bus.hwdata[8*n +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb_sram_sub.sv
// Directed bench: one instance with two wait states, one with zero.
module tb_ahb_sram_sub;
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ahb_sram_sub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m2 ();
   ahb_sram_sub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();

   ahb_sram_sub #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
      .i_hclk(clk), .i_hresetn(rst_n), .bus(m2.slave));
   ahb_sram_sub #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .i_hclk(clk), .i_hresetn(rst_n), .bus(m0.slave));

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
      end
   endtask

   task automatic drv2(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] sz);
      m2.htrans = tr; m2.haddr = a; m2.hwrite = w; m2.hsize = sz;
   endtask

   task automatic dat2(input logic [31:0] d, input logic [3:0] s);
      m2.hwdata = d; m2.hwstrb = s;
   endtask

   task automatic drv0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] sz);
      m0.htrans = tr; m0.haddr = a; m0.hwrite = w; m0.hsize = sz;
   endtask

   task automatic dat0(input logic [31:0] d, input logic [3:0] s);
      m0.hwdata = d; m0.hwstrb = s;
   endtask

   // Single transfer on the 2-wait instance; starts and ends at a negedge with the bus idle.
   task automatic xfer2(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp_rd,
                        input logic exp_err);
      logic [31:0] rd_exp;
      rd_exp = w ? 32'h0 : exp_rd;
      drv2(NONSEQ, a, w, sz);
      @(negedge clk);
      drv2(IDLE, 32'h0, 1'b0, 3'd0);
      dat2(wd, ws);
      if (exp_err) begin
         chk(tag, "err1_rdy", 32'(m2.hready), 32'd0);
         chk(tag, "err1_resp", 32'(m2.hresp), 32'd1);
         chk(tag, "err1_rdata", m2.hrdata, 32'h0);
         @(negedge clk);
         chk(tag, "err2_rdy", 32'(m2.hready), 32'd1);
         chk(tag, "err2_resp", 32'(m2.hresp), 32'd1);
      end else begin
         for (int i = 0; i < 2; i++) begin
            chk(tag, "wait_rdy", 32'(m2.hready), 32'd0);
            chk(tag, "wait_resp", 32'(m2.hresp), 32'd0);
            chk(tag, "wait_rdata", m2.hrdata, rd_exp);
            @(negedge clk);
         end
         chk(tag, "last_rdy", 32'(m2.hready), 32'd1);
         chk(tag, "last_resp", 32'(m2.hresp), 32'd0);
         chk(tag, "last_rdata", m2.hrdata, rd_exp);
      end
      @(negedge clk);
      chk(tag, "idle_rdy", 32'(m2.hready), 32'd1);
      chk(tag, "idle_resp", 32'(m2.hresp), 32'd0);
      chk(tag, "idle_rdata", m2.hrdata, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      drv2(IDLE, 32'h0, 1'b0, 3'd0); dat2(32'h0, 4'h0);
      drv0(IDLE, 32'h0, 1'b0, 3'd0); dat0(32'h0, 4'h0);
      m2.hburst = 3'd0; m2.hprot = 4'd0; m2.hmastlock = 1'b0;
      m0.hburst = 3'd0; m0.hprot = 4'd0; m0.hmastlock = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst", "rdy2", 32'(m2.hready), 32'd1);
      chk("rst", "resp2", 32'(m2.hresp), 32'd0);
      chk("rst", "rdata2", m2.hrdata, 32'h0);
      chk("rst", "rdy0", 32'(m0.hready), 32'd1);
      chk("rst", "resp0", 32'(m0.hresp), 32'd0);
      chk("rst", "rdata0", m0.hrdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst", "rdy2", 32'(m2.hready), 32'd1);

      // Byte write into a zeroed word, strobes and footprint
      xfer2("zero10", 32'h10, 1'b1, 3'd2, 32'h0000_0000, 4'hF, 32'h0, 1'b0);
      xfer2("byteAA", 32'h11, 1'b1, 3'd0, 32'h5555_AA55, 4'h2, 32'h0, 1'b0);
      xfer2("rd_AA", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0000_AA00, 1'b0);
      xfer2("byte_fp", 32'h11, 1'b1, 3'd0, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      xfer2("rd_fp", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0000_3300, 1'b0);

      // Word write then read with two wait states
      xfer2("wr_dead", 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      xfer2("rd_dead", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // Halfword footprint and partial strobe
      xfer2("half_hi", 32'h12, 1'b1, 3'd1, 32'hCAFE_1234, 4'hF, 32'h0, 1'b0);
      xfer2("rd_half", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'hCAFE_BEEF, 1'b0);
      xfer2("half_lo", 32'h10, 1'b1, 3'd1, 32'hFFFF_FF11, 4'h1, 32'h0, 1'b0);
      xfer2("rd_half2", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'hCAFE_BE11, 1'b0);

      // Illegal transfers: range, alignment, size; memory unchanged
      xfer2("wr_w0", 32'h00, 1'b1, 3'd2, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
      xfer2("rd_oor", 32'h400, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b1);
      xfer2("rd_unal", 32'h02, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b1);
      xfer2("wr_unal", 32'h02, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      xfer2("wr_hunal", 32'h01, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      xfer2("wr_sz3", 32'h00, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      xfer2("wr_oor", 32'h400, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      xfer2("rd_w0", 32'h00, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0102_0304, 1'b0);

      // Reset during the wait of a write aborts it
      xfer2("wr_30", 32'h30, 1'b1, 3'd2, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
      drv2(NONSEQ, 32'h30, 1'b1, 3'd2);
      @(negedge clk);
      drv2(IDLE, 32'h0, 1'b0, 3'd0);
      dat2(32'h9999_9999, 4'hF);
      chk("rst_mid", "wait_rdy", 32'(m2.hready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid", "rdy", 32'(m2.hready), 32'd1);
      chk("rst_mid", "resp", 32'(m2.hresp), 32'd0);
      chk("rst_mid", "rdata", m2.hrdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      xfer2("rd_30", 32'h30, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
      xfer2("rd_keep", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 32'hCAFE_BE11, 1'b0);

      // Burst with BUSY and IDLE inserted
      xfer2("wr_48", 32'h48, 1'b1, 3'd2, 32'h4848_4848, 4'hF, 32'h0, 1'b0);
      drv2(NONSEQ, 32'h40, 1'b1, 3'd2);
      @(negedge clk);
      drv2(BUSY, 32'h48, 1'b1, 3'd2);
      dat2(32'hA1A1_0001, 4'hF);
      chk("burst", "w1_rdy_a", 32'(m2.hready), 32'd0);
      @(negedge clk);
      chk("burst", "w1_rdy_b", 32'(m2.hready), 32'd0);
      @(negedge clk);
      chk("burst", "w1_last", 32'(m2.hready), 32'd1);
      @(negedge clk);
      chk("burst", "busy_rdy", 32'(m2.hready), 32'd1);
      chk("burst", "busy_resp", 32'(m2.hresp), 32'd0);
      dat2(32'hEEEE_EEEE, 4'hF);
      drv2(SEQ, 32'h44, 1'b1, 3'd2);
      @(negedge clk);
      drv2(IDLE, 32'h48, 1'b1, 3'd2);
      dat2(32'hA2A2_0002, 4'hF);
      chk("burst", "w2_rdy_a", 32'(m2.hready), 32'd0);
      @(negedge clk);
      chk("burst", "w2_rdy_b", 32'(m2.hready), 32'd0);
      @(negedge clk);
      chk("burst", "w2_last", 32'(m2.hready), 32'd1);
      @(negedge clk);
      chk("burst", "idle_rdy", 32'(m2.hready), 32'd1);
      chk("burst", "idle_resp", 32'(m2.hresp), 32'd0);
      dat2(32'h0, 4'h0);
      drv2(IDLE, 32'h0, 1'b0, 3'd0);
      @(negedge clk);
      xfer2("rd_40", 32'h40, 1'b0, 3'd2, 32'h0, 4'h0, 32'hA1A1_0001, 1'b0);
      xfer2("rd_44", 32'h44, 1'b0, 3'd2, 32'h0, 4'h0, 32'hA2A2_0002, 1'b0);
      xfer2("rd_48", 32'h48, 1'b0, 3'd2, 32'h0, 4'h0, 32'h4848_4848, 1'b0);

      // Zero-wait instance: back-to-back write then read
      drv0(NONSEQ, 32'h20, 1'b1, 3'd2);
      @(negedge clk);
      chk("zw", "wr_rdy", 32'(m0.hready), 32'd1);
      chk("zw", "wr_rdata", m0.hrdata, 32'h0);
      dat0(32'h1234_5678, 4'hF);
      drv0(NONSEQ, 32'h20, 1'b0, 3'd2);
      @(negedge clk);
      chk("zw", "rd_rdy", 32'(m0.hready), 32'd1);
      chk("zw", "rd_resp", 32'(m0.hresp), 32'd0);
      chk("zw", "rd_fwd", m0.hrdata, 32'h1234_5678);
      drv0(IDLE, 32'h0, 1'b0, 3'd0);
      dat0(32'h0, 4'h0);
      @(negedge clk);
      chk("zw", "idle_rdata", m0.hrdata, 32'h0);

      // Zero-wait pipelined stream: W W R R
      drv0(NONSEQ, 32'h24, 1'b1, 3'd2);
      @(negedge clk);
      dat0(32'hAAAA_0024, 4'hF);
      drv0(SEQ, 32'h28, 1'b1, 3'd2);
      @(negedge clk);
      chk("zw_pipe", "w2_rdy", 32'(m0.hready), 32'd1);
      dat0(32'hBBBB_0028, 4'hF);
      drv0(NONSEQ, 32'h24, 1'b0, 3'd2);
      @(negedge clk);
      dat0(32'h0, 4'h0);
      drv0(SEQ, 32'h28, 1'b0, 3'd2);
      chk("zw_pipe", "rd24", m0.hrdata, 32'hAAAA_0024);
      @(negedge clk);
      drv0(IDLE, 32'h0, 1'b0, 3'd0);
      chk("zw_pipe", "rd28", m0.hrdata, 32'hBBBB_0028);
      chk("zw_pipe", "rd28_rdy", 32'(m0.hready), 32'd1);
      @(negedge clk);
      chk("zw_pipe", "idle_rdata", m0.hrdata, 32'h0);

      // Zero-wait instance still takes two cycles for ERROR
      drv0(NONSEQ, 32'h400, 1'b0, 3'd2);
      @(negedge clk);
      drv0(IDLE, 32'h0, 1'b0, 3'd0);
      chk("zw_err", "err1_rdy", 32'(m0.hready), 32'd0);
      chk("zw_err", "err1_resp", 32'(m0.hresp), 32'd1);
      @(negedge clk);
      chk("zw_err", "err2_rdy", 32'(m0.hready), 32'd1);
      chk("zw_err", "err2_resp", 32'(m0.hresp), 32'd1);
      @(negedge clk);
      chk("zw_err", "after_resp", 32'(m0.hresp), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/ahb_sram_sub.md
AHB_SRAM_SUB -- requirements
Module: ahb_sram_sub

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-003 Parameter DEPTH, default 256, number of 32-bit words in storage (power of 2).
REQ-004 Parameter WAIT_STATES, default 1, range 0..7, wait cycles inserted per OKAY transfer.
REQ-005 HCLK  input  1  clock; all logic is on the rising edge.
REQ-006 HRESETn  input  1  reset; one clock, synchronous, active-low.
REQ-007 HADDR  input  ADDR_WIDTH  transfer byte address.
REQ-008 HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HSIZE  input  3  0=byte, 1=half, 2=word.
REQ-011 HBURST, HPROT, HMASTLOCK  input  3/4/1  accepted and ignored.
REQ-012 HWDATA  input  DATA_WIDTH  write data, valid in data phase.
REQ-013 HWSTRB  input  DATA_WIDTH/8  byte-lane write enables, valid in data phase.
REQ-014 HREADY  output  1  transfer complete / bus advance.
REQ-015 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-016 HRDATA  output  DATA_WIDTH  read data, valid when HREADY=1 on a read's final cycle.

Function
REQ-017 Point-to-point subordinate, always selected; an address phase is sampled only on an edge where HREADY=1 and HTRANS is NONSEQ or SEQ.
REQ-018 IDLE and BUSY transfers get a zero-wait OKAY; nothing else happens.
REQ-019 The FSM has 4 states: READY, WAIT, ERR1, ERR2.
REQ-020 READY: HREADY=1, HRESP=0.
REQ-021 Valid transfer sampled in READY, legal, WAIT_STATES>0 -> WAIT; wait counter loads WAIT_STATES-1.
REQ-022 WAIT: HREADY=0, HRESP=0; counter decrements each cycle; counter==0 -> READY.
REQ-023 The data phase of a transfer therefore lasts exactly WAIT_STATES+1 cycles.
REQ-024 WAIT_STATES=0 gives zero-wait OKAY; the FSM stays in READY.
REQ-025 Illegal transfer: HADDR word index >= DEPTH, HSIZE>2, or unaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0).
REQ-026 Illegal transfer sampled -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then READY; no memory access occurs.
REQ-027 Write: address, size and HWRITE are registered in the address phase; memory is updated on the final data-phase edge (HREADY=1) using HWDATA.
REQ-028 Write byte lane n is written iff HWSTRB[n]=1 and lane n lies inside the HSIZE/HADDR[1:0] footprint.
REQ-029 Read: HRDATA presents the full 32-bit stored word in every cycle of the data phase, ending with the HREADY=1 cycle.
REQ-030 Read-after-write to the same word in back-to-back transfers returns the new data; write data is forwarded when the read data phase overlaps the write commit edge.
REQ-031 Pipelining: a new address phase is sampled on the same edge that completes the previous data phase; zero-wait back-to-back transfers run at one per cycle.
REQ-032 Address-phase inputs are ignored while HREADY=0.
REQ-033 HRDATA is 0 outside read data phases.

Reset
REQ-034 HRESETn=0 at an edge forces state READY, wait counter 0, and the pending-transfer register invalid.
REQ-035 Outputs during and after reset: HREADY=1, HRESP=0, HRDATA=0.
REQ-036 Reset in mid-transfer aborts the transfer; a pending write is not committed.
REQ-037 Memory contents are not reset.

Verification
REQ-038 WAIT_STATES=2, write word 0xDEADBEEF to 0x10 with HWSTRB=0xF, then read 0x10 -> each data phase holds HREADY low 2 cycles; read returns 0xDEADBEEF, HRESP=0.
REQ-039 Byte write 0xAA to 0x11 (HSIZE=0, HWSTRB=0x2) over 0x00000000, then word read -> 0x0000AA00.
REQ-040 WAIT_STATES=0, back-to-back NONSEQ write 0x12345678 @0x20 then read @0x20 -> read completes the next cycle with 0x12345678 (forwarding).
REQ-041 Read at HADDR=4*DEPTH; then word read at 0x02 -> each gets ERR1 then ERR2 (HREADY 0 then 1, HRESP=1); memory is unchanged.
REQ-042 HRESETn=0 during WAIT of a write to 0x30 -> next cycle HREADY=1, HRESP=0; a later read of 0x30 returns its prior value.
REQ-043 BUSY/IDLE interleaved within a SEQ burst -> zero-wait OKAY on those transfers; no memory side effect.
